// File: rtl/nibacc_pkg.sv
// Shared types and helpers for the nibble-serial accumulator.
// Holds the nibble width, FSM state type and the adder carry-out term.
package nibacc_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } nibacc_state_t;

  // The adder cell has no carry-out, so it is rebuilt from the top bits.
  // Without a carry into bit 3 the sum bit q3 is a3^b3. With one, it is
  // the inverse. So (a3|b3) with q3 low means a carry left the nibble.
  function automatic logic nib_co(
    input logic a3,
    input logic b3,
    input logic q3
  );
    return (a3 & b3) | ((a3 | b3) & ~q3);
  endfunction

endpackage

// File: rtl/nib_add_co.sv
// 4-bit adder slice: sum of A+B+CI (no native carry-out) plus derived co.
// Ports: i_a, i_b nibble operands; i_ci carry-in; o_q sum; o_co carry-out.
module nib_add_co
  import nibacc_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_ci,
  output logic [NIB_W-1:0] o_q,
  output logic             o_co
);

  logic [NIB_W-1:0] w_q;

  // Adder cell: result truncated to the nibble, carry-out is discarded.
  assign w_q  = i_a + i_b + {{(NIB_W-1){1'b0}}, i_ci};
  assign o_q  = w_q;
  assign o_co = nib_co(i_a[NIB_W-1], i_b[NIB_W-1], w_q[NIB_W-1]);

endmodule

// File: rtl/nibble_serial_accum.sv
// W-bit accumulator that adds/subtracts a step one nibble per clock.
// Ports: CLK, RESET (async high), LOAD/D, START/STEP/SUB/CIN in;
//        ACC, BUSY, DONE (pulse), CO (final carry), ZERO out.
module nibble_serial_accum
  import nibacc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LOAD,
  input  logic [NIB_W*NIBBLES-1:0] D,
  input  logic                     START,
  input  logic [NIB_W*NIBBLES-1:0] STEP,
  input  logic                     SUB,
  input  logic                     CIN,
  output logic [NIB_W*NIBBLES-1:0] ACC,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     CO,
  output logic                     ZERO
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  nibacc_state_t r_state;
  nibacc_state_t w_next;

  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_step;
  logic             r_mode;
  logic             r_carry;
  logic             r_done;
  logic             r_co;
  logic [IW-1:0]    r_idx;

  logic             w_last;
  logic             w_load;
  logic             w_go;
  logic [NIB_W-1:0] w_a;
  logic [NIB_W-1:0] w_b;
  logic [NIB_W-1:0] w_q;
  logic             w_co;

  // Nibble mux: current slice of ACC and the (possibly inverted) step.
  assign w_a    = r_acc[r_idx*NIB_W +: NIB_W];
  assign w_b    = r_step[r_idx*NIB_W +: NIB_W] ^ {NIB_W{r_mode}};
  assign w_last = (r_idx == LAST_IDX);

  nib_add_co u_add (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_ci (r_carry),
    .o_q  (w_q),
    .o_co (w_co)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // LOAD wins over START; a dropped START produces no DONE.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_go   = 1'b0;
    case (r_state)
      IDLE: begin
        if (LOAD) begin
          w_load = 1'b1;
        end else if (START) begin
          w_go   = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_acc   <= '0;
      r_step  <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_acc <= D;
      end
      // Subtract is A + ~B + 1, so the first carry-in is forced high.
      if (w_go) begin
        r_step  <= STEP;
        r_mode  <= SUB;
        r_carry <= SUB | CIN;
        r_idx   <= '0;
      end
      if (r_state == RUN) begin
        r_acc[r_idx*NIB_W +: NIB_W] <= w_q;
        r_carry <= w_co;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_done <= 1'b1;
          r_co   <= w_co;
        end
      end
    end
  end

  assign ACC  = r_acc;
  assign BUSY = (r_state == RUN);
  assign DONE = r_done;
  assign CO   = r_co;
  assign ZERO = (r_acc == '0);

endmodule
